// File: rtl/vga_text_pkg.sv
// Shared types and defaults for the VGA text character buffer.
// The CLR_ROW state exists only when TEXT_BUF_SCROLL_EN is defined.
package vga_text_pkg;

  localparam int COLS_DEFAULT = 80;
  localparam int ROWS_DEFAULT = 30;
  localparam logic [7:0] FILL_DEFAULT = 8'h20;

`ifdef TEXT_BUF_SCROLL_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ALL = 2'd1,
    CLR_ROW = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ALL = 2'd1
  } state_e;
`endif

endpackage

// File: rtl/vga_text_ram.sv
// Single-clock simple dual-port character RAM, read-first, registered output.
// Only the output register is reset; the array contents are not.
module vga_text_ram #(
  parameter int DEPTH  = 2400,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Write port; a same-edge read sees the previous contents
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/vga_text_ctrl.sv
// COLS x ROWS character buffer with clear-screen engine and optional
// ring-buffer scroll (enabled by defining TEXT_BUF_SCROLL_EN).
module vga_text_ctrl
  import vga_text_pkg::*;
#(
  parameter int          COLS   = COLS_DEFAULT,
  parameter int          ROWS   = ROWS_DEFAULT,
  parameter int          DATA_W = 8,
  parameter logic [7:0]  FILL   = FILL_DEFAULT,
  localparam int         COL_W  = $clog2(COLS),
  localparam int         ROW_W  = $clog2(ROWS),
  localparam int         ADDR_W = $clog2(COLS * ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [COL_W-1:0]  rd_col,
  input  logic [ROW_W-1:0]  rd_row,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_req,
  input  logic              scroll_req,
  output logic              busy
);

  localparam int                CELLS    = COLS * ROWS;
  localparam logic [DATA_W-1:0] FILL_W   = DATA_W'(FILL);
  localparam logic [ADDR_W-1:0] LAST_ALL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [COL_W:0]    COLS_L   = (COL_W + 1)'(COLS);
  localparam logic [ROW_W:0]    ROWS_L   = (ROW_W + 1)'(ROWS);

  // Logical (col,row) to physical address; row and top are both below ROWS
  function automatic logic [ADDR_W-1:0] map_addr(input logic [COL_W-1:0] col,
                                                 input logic [ROW_W-1:0] row,
                                                 input logic [ROW_W-1:0] top);
    logic [ROW_W:0] sum;
    logic [ROW_W:0] prow;
    sum  = {1'b0, row} + {1'b0, top};
    prow = (sum >= ROWS_L) ? (sum - ROWS_L) : sum;
    return (ADDR_W'(prow) * COLS_A) + ADDR_W'(col);
  endfunction

  state_e            state_r;
  state_e            next_state_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] eng_addr_s;
  logic              eng_we_s;
  logic              eng_last_s;
  logic              busy_r;
  logic [ROW_W-1:0]  top_s;

  logic              wr_ok_s;
  logic              wr_vld_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;

  logic              rd_ok_s;
  logic              rd_req_r;
  logic              rd_oor_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              rd_valid_r;
  logic              rd_fill_r;
  logic [DATA_W-1:0] ram_q_s;

`ifdef TEXT_BUF_SCROLL_EN
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  TOP_MAX  = ROW_W'(ROWS - 1);

  logic [ROW_W-1:0]  top_r;
  logic [ADDR_W-1:0] row_base_r;

  // Ring-buffer top row; clear wins over scroll in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      top_r      <= '0;
      row_base_r <= '0;
    end else if ((state_r == IDLE) && clr_req) begin
      top_r      <= '0;
    end else if ((state_r == IDLE) && scroll_req) begin
      top_r      <= (top_r == TOP_MAX) ? '0 : (top_r + ROW_W'(1));
      row_base_r <= ADDR_W'(top_r) * COLS_A;
    end
  end

  assign top_s = top_r;
`else
  logic unused_scroll_s;
  assign unused_scroll_s = scroll_req;
  assign top_s           = '0;
`endif

  // Engine next state and the fill address it drives this cycle
  always_comb begin
    next_state_s = state_r;
    eng_we_s     = 1'b0;
    eng_addr_s   = cnt_r;
    eng_last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          next_state_s = CLR_ALL;
`ifdef TEXT_BUF_SCROLL_EN
        end else if (scroll_req) begin
          next_state_s = CLR_ROW;
`endif
        end else begin
          next_state_s = IDLE;
        end
      end
      CLR_ALL: begin
        eng_we_s     = 1'b1;
        eng_addr_s   = cnt_r;
        eng_last_s   = (cnt_r == LAST_ALL);
        next_state_s = eng_last_s ? IDLE : CLR_ALL;
      end
`ifdef TEXT_BUF_SCROLL_EN
      CLR_ROW: begin
        eng_we_s     = 1'b1;
        eng_addr_s   = row_base_r + cnt_r;
        eng_last_s   = (cnt_r == LAST_ROW);
        next_state_s = eng_last_s ? IDLE : CLR_ROW;
      end
`endif
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Engine state, cell counter and registered busy flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= ((state_r == IDLE) || eng_last_s) ? '0 : (cnt_r + ADDR_W'(1));
      busy_r  <= (next_state_s != IDLE);
    end
  end

  assign wr_ok_s = wr_en && (state_r == IDLE) &&
                   ({1'b0, wr_col} < COLS_L) && ({1'b0, wr_row} < ROWS_L);
  assign rd_ok_s = ({1'b0, rd_col} < COLS_L) && ({1'b0, rd_row} < ROWS_L);

  // Write pipeline stage; the engine owns it while busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_vld_r  <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
    end else if (eng_we_s) begin
      wr_vld_r  <= 1'b1;
      wr_addr_r <= eng_addr_s;
      wr_data_r <= FILL_W;
    end else begin
      wr_vld_r  <= wr_ok_s;
      wr_addr_r <= map_addr(wr_col, wr_row, top_s);
      wr_data_r <= wr_data;
    end
  end

  // Read pipeline: address stage, then valid/fill flags aligned to RAM output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_req_r   <= 1'b0;
      rd_oor_r   <= 1'b0;
      rd_addr_r  <= '0;
      rd_valid_r <= 1'b0;
      rd_fill_r  <= 1'b0;
    end else begin
      rd_req_r   <= rd_en;
      rd_oor_r   <= rd_en && !rd_ok_s;
      rd_addr_r  <= rd_ok_s ? map_addr(rd_col, rd_row, top_s) : '0;
      rd_valid_r <= rd_req_r;
      rd_fill_r  <= rd_oor_r;
    end
  end

  vga_text_ram #(
    .DEPTH  (CELLS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_vld_r),
    .waddr (wr_addr_r),
    .wdata (wr_data_r),
    .re    (rd_req_r && !rd_oor_r),
    .raddr (rd_addr_r),
    .rdata (ram_q_s)
  );

  assign rd_data  = rd_fill_r ? FILL_W : ram_q_s;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Scoreboard bench for vga_text_ctrl: a physical-array model predicts every read.
// Scroll scenarios follow TEXT_BUF_SCROLL_EN in the same way as the design.
module tb_vga_text_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [6:0] wr_col = 7'd0;
  logic [4:0] wr_row = 5'd0;
  logic [7:0] wr_data = 8'd0;
  logic       rd_en = 1'b0;
  logic [6:0] rd_col = 7'd0;
  logic [4:0] rd_row = 5'd0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       clr_req = 1'b0;
  logic       scroll_req = 1'b0;
  logic       busy;

  vga_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .DATA_W(8), .FILL(8'h20)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
    .rd_en(rd_en), .rd_col(rd_col), .rd_row(rd_row),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_req(clr_req), .scroll_req(scroll_req), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] mdl [CELLS];
  int mtop = 0;
  logic [7:0] sb_data [$];
  int sb_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every rd_valid pops one expectation (data and arrival cycle)
  always @(negedge clk) begin
    logic [7:0] exp_d;
    int exp_c;
    if (rst_n && rd_valid) begin
      n_checks++;
      if (sb_data.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: rd_valid=1 rd_data=%h, required no read outstanding", rd_data);
      end else begin
        exp_d = sb_data.pop_front();
        exp_c = sb_cyc.pop_front();
        if (rd_data !== exp_d || cyc != exp_c)
          begin
            n_fail++;
            $display("FAIL rd_data: got %h at cycle %0d, required %h at cycle %0d", rd_data, cyc, exp_d, exp_c);
          end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int paddr(int c, int r);
    return ((r + mtop) % ROWS) * COLS + c;
  endfunction

  function automatic logic [7:0] mexp(int c, int r);
    if (c >= COLS || r >= ROWS) return 8'h20;
    return mdl[paddr(c, r)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of port activity; a read predicts before the model sees the write
  task automatic issue(input bit we, input int wc, input int wrw, input logic [7:0] wd,
                       input bit re, input int rc, input int rr);
    wr_en = we; wr_col = 7'(wc); wr_row = 5'(wrw); wr_data = wd;
    rd_en = re; rd_col = 7'(rc); rd_row = 5'(rr);
    if (re) begin
      sb_data.push_back(mexp(rc, rr));
      sb_cyc.push_back(cyc + 2);
    end
    if (we && wc < COLS && wrw < ROWS) mdl[paddr(wc, wrw)] = wd;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input int c, input int r, input logic [7:0] d);
    issue(1'b1, c, r, d, 1'b0, 0, 0);
  endtask

  task automatic rd(input int c, input int r);
    issue(1'b0, 0, 0, 8'h00, 1'b1, c, r);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_data.size() != 0; i++) tick();
  endtask

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) mdl[i] = 8'h20;
    mtop = 0;
  endtask

  // Count busy cycles; optionally inject a write or scroll request mid-run
  task automatic measure_busy(output int n, input int inj_at, input bit inj_scroll);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == inj_at) begin
        if (inj_scroll) scroll_req = 1'b1;
        else begin wr_en = 1'b1; wr_col = 7'd0; wr_row = 5'd0; wr_data = 8'hAA; end
      end else if (i == inj_at + 1) begin
        scroll_req = 1'b0; wr_en = 1'b0;
      end
      if (!busy) break;
      n++;
    end
    scroll_req = 1'b0; wr_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb_data.delete(); sb_cyc.delete();
    mtop = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_checks += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b, required 0", rd_valid); end
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h, required 00", rd_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    int n;
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    model_clear();
    measure_busy(n, 100, 1'b0);
    n_checks++;
    if (n != CELLS) begin n_fail++; $display("FAIL clear_busy_len: got %0d cycles, required %0d", n, CELLS); end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) rd(c, r);
    drain();
  endtask

  task automatic test_write_read();
    wr(5, 2, 8'h41);
    rd(5, 2);
    issue(1'b1, 5, 2, 8'h42, 1'b1, 5, 2);
    rd(5, 2);
    for (int i = 0; i < 16; i++) wr((i * 5) % COLS, (i * 7) % ROWS, 8'(i * 13 + 7));
    for (int i = 0; i < 16; i++) rd((i * 5) % COLS, (i * 7) % ROWS);
    drain();
  endtask

  task automatic test_oor();
    wr(79, 29, 8'h9C);
    wr(3, 31, 8'h77);
    wr(85, 0, 8'h66);
    rd(80, 0);
    rd(0, 30);
    rd(127, 31);
    rd(3, 1);
    rd(5, 1);
    rd(79, 29);
    drain();
  endtask

  task automatic test_back_to_back_pattern();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wr(c, r, 8'(r * 7 + c));
    tick();
    pulse_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) rd(c, r);
    drain();
  endtask

`ifdef TEXT_BUF_SCROLL_EN
  task automatic do_scroll(input int inj_at);
    int n;
    int hi;
    scroll_req = 1'b1; tick(); scroll_req = 1'b0;
    for (int c = 0; c < COLS; c++) mdl[mtop * COLS + c] = 8'h20;
    mtop = (mtop + 1) % ROWS;
    measure_busy(n, inj_at, 1'b1);
    n_checks++;
    if (n != COLS) begin n_fail++; $display("FAIL scroll_busy_len: got %0d cycles, required %0d", n, COLS); end
    hi = 0;
    repeat (5) begin @(negedge clk); if (busy) hi++; end
    tick();
    n_checks++;
    if (hi != 0) begin n_fail++; $display("FAIL scroll_requeued: busy seen %0d cycles after end, required 0", hi); end
  endtask

  task automatic test_scroll();
    for (int c = 0; c < COLS; c++) wr(c, 0, 8'(8'h30 + c));
    for (int c = 0; c < COLS; c++) wr(c, 1, 8'(8'h80 + c));
    do_scroll(10);
    for (int c = 0; c < COLS; c++) rd(c, 29);
    for (int c = 0; c < COLS; c++) rd(c, 0);
    drain();
    for (int k = 0; k < ROWS - 1; k++) do_scroll(-5);
    test_back_to_back_pattern();
  endtask
`else
  task automatic test_scroll();
    int hi;
    wr(0, 0, 8'h11);
    wr(0, 1, 8'h22);
    scroll_req = 1'b1; tick(); scroll_req = 1'b0;
    hi = 0;
    repeat (5) begin @(negedge clk); if (busy) hi++; end
    tick();
    n_checks++;
    if (hi != 0) begin n_fail++; $display("FAIL noscroll_busy: busy seen %0d cycles, required 0", hi); end
    rd(0, 0);
    rd(0, 1);
    rd(0, 29);
    drain();
    test_back_to_back_pattern();
  endtask
`endif

  task automatic test_clr_scroll_same();
    int n;
`ifdef TEXT_BUF_SCROLL_EN
    do_scroll(-5);
`endif
    clr_req = 1'b1; scroll_req = 1'b1; tick(); clr_req = 1'b0; scroll_req = 1'b0;
    model_clear();
    measure_busy(n, 20, 1'b1);
    n_checks++;
    if (n != CELLS) begin n_fail++; $display("FAIL clr_scroll_busy_len: got %0d cycles, required %0d", n, CELLS); end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < COLS; c++) wr(c, r, 8'(8'h50 + r * 16 + c));
    tick();
    pulse_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < COLS; c++) rd(c, r);
    rd(0, 29);
    drain();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    for (int c = 0; c < COLS; c++) wr(c, 20, 8'(8'hC0 + c));
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (100) tick();
    rd_en = 1'b1; rd_col = 7'd0; rd_row = 5'd20;
    tick();
    rd_en = 1'b0;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    n_checks += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midclr_busy: got %b, required 0", busy); end
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL midclr_rd_valid: got %b, required 0", rd_valid); end
    rst_n = 1'b1;
    sb_data.delete(); sb_cyc.delete();
    mtop = 0;
    for (int i = 0; i < 50; i++) mdl[i] = 8'h20;
    tick();
    measure_busy(n, -5, 1'b0);
    n_checks++;
    if (n != 0) begin n_fail++; $display("FAIL midclr_engine: busy %0d cycles after reset, required 0", n); end
    for (int c = 0; c < COLS; c++) rd(c, 20);
    rd(0, 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write_read();
    test_oor();
    test_scroll();
    test_clr_scroll_same();
    test_reset_mid_clear();
    n_checks++;
    if (sb_data.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty: %0d reads outstanding, required 0", sb_data.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
